// File: rtl/int_ctrl_pkg.sv
// Shared defines for the 8051 interrupt controller: IE/IP bit positions,
// source indices, vector addresses and FSM encoding.
package int_ctrl_pkg;

   localparam int EA_BIT  = 7;
   localparam int ES0_BIT = 4;
   localparam int ET1_BIT = 3;
   localparam int EX1_BIT = 2;
   localparam int ET0_BIT = 1;
   localparam int EX0_BIT = 0;

   localparam int NUM_SRC = 5;

   localparam logic [2:0] SRC_IE0 = 3'd0;
   localparam logic [2:0] SRC_TF0 = 3'd1;
   localparam logic [2:0] SRC_IE1 = 3'd2;
   localparam logic [2:0] SRC_TF1 = 3'd3;
   localparam logic [2:0] SRC_SER = 3'd4;

   // IE/IP bit that gates each source, in source (polling) order
   localparam int SRC_BIT [NUM_SRC] = '{EX0_BIT, ET0_BIT, EX1_BIT, ET1_BIT, ES0_BIT};

   localparam logic [15:0] VEC_IE0 = 16'h0003;
   localparam logic [15:0] VEC_TF0 = 16'h000B;
   localparam logic [15:0] VEC_IE1 = 16'h0013;
   localparam logic [15:0] VEC_TF1 = 16'h001B;
   localparam logic [15:0] VEC_SER = 16'h0023;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } state_t;

   function automatic logic [15:0] vector_of(input logic [2:0] src);
      case (src)
         SRC_IE0: vector_of = VEC_IE0;
         SRC_TF0: vector_of = VEC_TF0;
         SRC_IE1: vector_of = VEC_IE1;
         SRC_TF1: vector_of = VEC_TF1;
         SRC_SER: vector_of = VEC_SER;
         default: vector_of = 16'h0000;
      endcase
   endfunction

   // Timer flags always clear on ack; external flags only when edge-triggered
   function automatic logic hw_clearable(input logic [2:0] src, input logic [1:0] edge_trig);
      case (src)
         SRC_TF0, SRC_TF1: hw_clearable = 1'b1;
         SRC_IE0:          hw_clearable = edge_trig[0];
         SRC_IE1:          hw_clearable = edge_trig[1];
         default:          hw_clearable = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/int_ctrl_if.sv
// Bus between the SFR block / sequencer (master) and the interrupt controller (slave).
interface int_ctrl_if;
   import int_ctrl_pkg::*;

   logic [7:0]         ie;
   logic [7:0]         ip;
   logic [NUM_SRC-1:0] flags;
   logic [1:0]         edge_trig;
   logic               inhibit;
   logic               int_ack;
   logic               reti;
   logic               int_req;
   logic [15:0]        vector;
   logic [NUM_SRC-1:0] clr_flag;
   logic [1:0]         in_service;

   modport master (
      output ie, ip, flags, edge_trig, inhibit, int_ack, reti,
      input  int_req, vector, clr_flag, in_service
   );

   modport slave (
      input  ie, ip, flags, edge_trig, inhibit, int_ack, reti,
      output int_req, vector, clr_flag, in_service
   );

endinterface

// File: rtl/int_prio_enc.sv
// Fixed-order priority encoder: lowest set bit of the qualified mask wins.
module int_prio_enc
   import int_ctrl_pkg::*;
(
   input  logic [NUM_SRC-1:0] mask,
   output logic               valid,
   output logic [2:0]         idx
);

   always_comb begin
      valid = |mask;
      idx   = 3'd0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (mask[i]) idx = 3'(i);
      end
   end

endmodule

// File: rtl/int_ctrl.sv
// 8051 interrupt controller: two-level arbitration, vectored request to the
// sequencer, in-service nesting and hardware flag clearing on acknowledge.
module int_ctrl
   import int_ctrl_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   int_ctrl_if.slave  bus
);

   state_t             state_reg, state_next;
   logic [2:0]         src_reg, src_next;
   logic               lvl_reg, lvl_next;
   logic [15:0]        vector_reg, vector_next;
   logic [NUM_SRC-1:0] clr_flag_reg, clr_flag_next;
   logic [1:0]         in_service_reg, in_service_next;

   logic [NUM_SRC-1:0] src_en, src_hi, eligible, hi_mask, lo_mask;
   logic               hi_valid, lo_valid, win_valid, win_hi, latched_eligible;
   logic [2:0]         hi_idx, lo_idx, win_idx;
   logic               unused_bits;

   for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign src_en[gi] = bus.ie[SRC_BIT[gi]];
      assign src_hi[gi] = bus.ip[SRC_BIT[gi]];
   end

   assign unused_bits = ^{bus.ie[6:5], bus.ip[7:5]};

   assign eligible = src_en & bus.flags & {NUM_SRC{bus.ie[EA_BIT]}};
   // High may nest over low; low only runs when nothing is in service
   assign hi_mask  = eligible &  src_hi & {NUM_SRC{~in_service_reg[1]}};
   assign lo_mask  = eligible & ~src_hi & {NUM_SRC{in_service_reg == 2'b00}};

   int_prio_enc u_enc_hi (.mask(hi_mask), .valid(hi_valid), .idx(hi_idx));
   int_prio_enc u_enc_lo (.mask(lo_mask), .valid(lo_valid), .idx(lo_idx));

   assign win_valid        = hi_valid | lo_valid;
   assign win_hi           = hi_valid;
   assign win_idx          = hi_valid ? hi_idx : lo_idx;
   assign latched_eligible = |(eligible & (NUM_SRC'(1) << src_reg));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg      <= ST_IDLE;
         src_reg        <= 3'd0;
         lvl_reg        <= 1'b0;
         vector_reg     <= 16'h0000;
         clr_flag_reg   <= '0;
         in_service_reg <= 2'b00;
      end else begin
         state_reg      <= state_next;
         src_reg        <= src_next;
         lvl_reg        <= lvl_next;
         vector_reg     <= vector_next;
         clr_flag_reg   <= clr_flag_next;
         in_service_reg <= in_service_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      src_next        = src_reg;
      lvl_next        = lvl_reg;
      vector_next     = vector_reg;
      clr_flag_next   = '0;
      in_service_next = in_service_reg;

      // RETI retires the innermost active level; ack below may set a level in the same cycle
      if (bus.reti) begin
         if (in_service_reg[1])      in_service_next[1] = 1'b0;
         else if (in_service_reg[0]) in_service_next[0] = 1'b0;
      end

      case (state_reg)
         ST_IDLE: begin
            if (win_valid && !bus.inhibit) begin
               state_next  = ST_REQ;
               src_next    = win_idx;
               lvl_next    = win_hi;
               vector_next = vector_of(win_idx);
            end
         end
         ST_REQ: begin
            if (bus.int_ack) begin
               state_next                = ST_IDLE;
               in_service_next[lvl_reg]  = 1'b1;
               if (hw_clearable(src_reg, bus.edge_trig))
                  clr_flag_next = NUM_SRC'(1) << src_reg;
            end else if (!latched_eligible) begin
               state_next = ST_IDLE;
            end
         end
      endcase
   end

   always_comb begin
      bus.int_req    = (state_reg == ST_REQ);
      bus.vector     = vector_reg;
      bus.clr_flag   = clr_flag_reg;
      bus.in_service = in_service_reg;
   end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed scenarios plus randomized traffic checked against a cycle-level
// behavioural model of the interrupt controller.
module tb_int_ctrl;

   logic i_clk = 1'b0;
   logic i_rst = 1'b1;

   int_ctrl_if bus();

   int_ctrl dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bus));

   always #5 i_clk = ~i_clk;

   int errors = 0;
   int checks = 0;

   // reference model state
   bit          m_pending;
   int          m_src;
   bit          m_hi;
   logic [15:0] m_vec;
   logic [1:0]  m_ins;
   logic [4:0]  m_clr;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.ie = 8'h00; bus.ip = 8'h00; bus.flags = 5'b0; bus.edge_trig = 2'b00;
      bus.inhibit = 1'b0; bus.int_ack = 1'b0; bus.reti = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      i_rst = 1'b1;
      tick();
      tick();
      i_rst = 1'b0;
   endtask

   function automatic bit m_elig(int s);
      return bus.ie[7] && bus.ie[s] && bus.flags[s];
   endfunction

   // One clock of the controller described by its rules, using the current inputs
   task automatic model_step();
      logic [1:0] ins_n;
      logic [4:0] clr_n;
      bit         found;
      ins_n = m_ins;
      clr_n = 5'b0;
      if (bus.reti) begin
         if (m_ins[1])      ins_n[1] = 1'b0;
         else if (m_ins[0]) ins_n[0] = 1'b0;
      end
      if (m_pending) begin
         if (bus.int_ack) begin
            ins_n[m_hi] = 1'b1;
            if (m_src == 1 || m_src == 3 || (m_src == 0 && bus.edge_trig[0]) ||
                (m_src == 2 && bus.edge_trig[1]))
               clr_n[m_src] = 1'b1;
            m_pending = 1'b0;
         end else if (!m_elig(m_src)) begin
            m_pending = 1'b0;
         end
      end else if (!bus.inhibit) begin
         found = 1'b0;
         for (int lvl = 1; lvl >= 0; lvl--) begin
            bit allowed;
            allowed = (lvl == 1) ? !m_ins[1] : (m_ins == 2'b00);
            for (int s = 0; s < 5; s++) begin
               if (!found && allowed && m_elig(s) && (bus.ip[s] == lvl[0])) begin
                  found     = 1'b1;
                  m_pending = 1'b1;
                  m_src     = s;
                  m_hi      = lvl[0];
                  m_vec     = 16'(3 + 8 * s);
               end
            end
         end
      end
      m_ins = ins_n;
      m_clr = clr_n;
   endtask

   task automatic test_reset();
      bus.ie = 8'h83; bus.flags = 5'b00010;
      i_rst = 1'b1;
      tick();
      checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", bus.int_req); end
      checks++; if (bus.vector !== 16'h0000) begin errors++; $display("FAIL reset_vector got=%h exp=0000", bus.vector); end
      checks++; if (bus.clr_flag !== 5'b0) begin errors++; $display("FAIL reset_clr got=%b exp=00000", bus.clr_flag); end
      checks++; if (bus.in_service !== 2'b00) begin errors++; $display("FAIL reset_ins got=%b exp=00", bus.in_service); end
      do_reset();
   endtask

   task automatic test_tf0();
      do_reset();
      bus.ie = 8'h83; bus.flags = 5'b00010;
      tick();
      checks++; if (bus.int_req !== 1'b1) begin errors++; $display("FAIL tf0_req got=%b exp=1", bus.int_req); end
      checks++; if (bus.vector !== 16'h000B) begin errors++; $display("FAIL tf0_vector got=%h exp=000b", bus.vector); end
      bus.int_ack = 1'b1;
      tick();
      $display("tf0 ack: vector=000b clr=%b in_service=%b", bus.clr_flag, bus.in_service);
      checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL tf0_req_drop got=%b exp=0", bus.int_req); end
      checks++; if (bus.clr_flag !== 5'b00010) begin errors++; $display("FAIL tf0_clr got=%b exp=00010", bus.clr_flag); end
      checks++; if (bus.in_service !== 2'b01) begin errors++; $display("FAIL tf0_ins got=%b exp=01", bus.in_service); end
      bus.int_ack = 1'b0; bus.flags = 5'b0;
      tick();
      checks++; if (bus.clr_flag !== 5'b0) begin errors++; $display("FAIL tf0_clr_pulse got=%b exp=00000", bus.clr_flag); end
   endtask

   task automatic test_high_beats_order();
      do_reset();
      bus.ie = 8'h9F; bus.ip = 8'h10; bus.flags = 5'b10001;
      tick();
      checks++; if (bus.vector !== 16'h0023 || bus.int_req !== 1'b1) begin errors++; $display("FAIL hi_vector got=%h req=%b exp=0023", bus.vector, bus.int_req); end
      bus.int_ack = 1'b1;
      tick();
      $display("serial ack: clr=%b in_service=%b", bus.clr_flag, bus.in_service);
      checks++; if (bus.clr_flag !== 5'b0) begin errors++; $display("FAIL hi_clr got=%b exp=00000", bus.clr_flag); end
      checks++; if (bus.in_service !== 2'b10) begin errors++; $display("FAIL hi_ins got=%b exp=10", bus.in_service); end
      bus.int_ack = 1'b0; bus.flags = 5'b00001;
      tick();
      checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL hi_blocks_low got=%b exp=0", bus.int_req); end
   endtask

   task automatic test_nesting();
      do_reset();
      bus.ie = 8'h81; bus.ip = 8'h08; bus.flags = 5'b00001; bus.edge_trig = 2'b01;
      tick();
      checks++; if (bus.vector !== 16'h0003) begin errors++; $display("FAIL nest_low_vec got=%h exp=0003", bus.vector); end
      bus.int_ack = 1'b1;
      tick();
      checks++; if (bus.in_service !== 2'b01 || bus.clr_flag !== 5'b00001) begin errors++; $display("FAIL nest_low_ack ins=%b clr=%b exp=01/00001", bus.in_service, bus.clr_flag); end
      bus.int_ack = 1'b0; bus.flags = 5'b01000; bus.ie = 8'h88;
      tick();
      checks++; if (bus.int_req !== 1'b1 || bus.vector !== 16'h001B) begin errors++; $display("FAIL nest_high_req req=%b vec=%h exp=1/001b", bus.int_req, bus.vector); end
      bus.int_ack = 1'b1;
      tick();
      $display("nested ack: in_service=%b clr=%b", bus.in_service, bus.clr_flag);
      checks++; if (bus.in_service !== 2'b11 || bus.clr_flag !== 5'b01000) begin errors++; $display("FAIL nest_high_ack ins=%b clr=%b exp=11/01000", bus.in_service, bus.clr_flag); end
      bus.int_ack = 1'b0;
      tick();
      tick();
      checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL nest_suppress got=%b exp=0", bus.int_req); end
      bus.flags = 5'b0; bus.reti = 1'b1;
      tick();
      checks++; if (bus.in_service !== 2'b01) begin errors++; $display("FAIL reti1 got=%b exp=01", bus.in_service); end
      tick();
      checks++; if (bus.in_service !== 2'b00) begin errors++; $display("FAIL reti2 got=%b exp=00", bus.in_service); end
      tick();
      checks++; if (bus.in_service !== 2'b00) begin errors++; $display("FAIL reti_idle got=%b exp=00", bus.in_service); end
      bus.reti = 1'b0;
   endtask

   task automatic test_level_vs_edge();
      for (int e = 0; e < 2; e++) begin
         do_reset();
         bus.ie = 8'h84; bus.flags = 5'b00100; bus.edge_trig = (e == 1) ? 2'b10 : 2'b00;
         tick();
         checks++; if (bus.vector !== 16'h0013) begin errors++; $display("FAIL ie1_vec got=%h exp=0013", bus.vector); end
         bus.int_ack = 1'b1;
         tick();
         $display("ie1 ack it1=%0d: clr=%b", e, bus.clr_flag);
         checks++; if (bus.clr_flag !== ((e == 1) ? 5'b00100 : 5'b00000)) begin errors++; $display("FAIL ie1_clr it1=%0d got=%b", e, bus.clr_flag); end
         bus.int_ack = 1'b0;
      end
   endtask

   task automatic test_withdraw_inhibit();
      do_reset();
      bus.ie = 8'h82; bus.flags = 5'b00010;
      tick();
      checks++; if (bus.int_req !== 1'b1) begin errors++; $display("FAIL wd_req got=%b exp=1", bus.int_req); end
      bus.ie = 8'h02;
      tick();
      checks++; if (bus.int_req !== 1'b0 || bus.in_service !== 2'b00 || bus.clr_flag !== 5'b0) begin errors++; $display("FAIL withdraw req=%b ins=%b clr=%b exp=0/00/00000", bus.int_req, bus.in_service, bus.clr_flag); end
      bus.ie = 8'h82; bus.inhibit = 1'b1;
      tick();
      tick();
      checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL inhibit got=%b exp=0", bus.int_req); end
      bus.inhibit = 1'b0;
      tick();
      checks++; if (bus.int_req !== 1'b1 || bus.vector !== 16'h000B) begin errors++; $display("FAIL post_inhibit req=%b vec=%h exp=1/000b", bus.int_req, bus.vector); end
   endtask

   task automatic test_reset_mid_req();
      do_reset();
      bus.ie = 8'h82; bus.flags = 5'b00010;
      tick();
      i_rst = 1'b1; bus.int_ack = 1'b1;
      tick();
      checks++; if (bus.int_req !== 1'b0 || bus.vector !== 16'h0 || bus.clr_flag !== 5'b0 || bus.in_service !== 2'b00) begin errors++; $display("FAIL rst_mid_req req=%b vec=%h clr=%b ins=%b exp=all zero", bus.int_req, bus.vector, bus.clr_flag, bus.in_service); end
      i_rst = 1'b0; bus.int_ack = 1'b0;
   endtask

   task automatic test_ack_reti_same();
      do_reset();
      bus.ie = 8'h81; bus.flags = 5'b00001; bus.edge_trig = 2'b01;
      tick();
      bus.int_ack = 1'b1;
      tick();
      bus.int_ack = 1'b0; bus.flags = 5'b01000; bus.ie = 8'h88; bus.ip = 8'h08;
      tick();
      checks++; if (bus.vector !== 16'h001B) begin errors++; $display("FAIL ackreti_vec got=%h exp=001b", bus.vector); end
      bus.int_ack = 1'b1; bus.reti = 1'b1;
      tick();
      $display("ack+reti: in_service=%b clr=%b", bus.in_service, bus.clr_flag);
      checks++; if (bus.in_service !== 2'b10) begin errors++; $display("FAIL ackreti_ins got=%b exp=10", bus.in_service); end
      bus.int_ack = 1'b0; bus.reti = 1'b0;
   endtask

   task automatic test_random();
      do_reset();
      m_pending = 1'b0; m_src = 0; m_hi = 1'b0; m_vec = 16'h0; m_ins = 2'b00; m_clr = 5'b0;
      for (int n = 0; n < 500; n++) begin
         bus.ie        = 8'($urandom);
         bus.ie[7]     = ($urandom_range(0, 3) != 0);
         bus.ip        = 8'($urandom);
         bus.flags     = 5'($urandom & $urandom);
         bus.edge_trig = 2'($urandom);
         bus.inhibit   = ($urandom_range(0, 4) == 0);
         bus.int_ack   = m_pending && ($urandom_range(0, 1) == 1);
         bus.reti      = ($urandom_range(0, 5) == 0);
         if (bus.int_ack) $display("rand ack n=%0d src=%0d vec=%h", n, m_src, m_vec);
         model_step();
         tick();
         checks++; if (bus.int_req !== m_pending) begin errors++; $display("FAIL rand_req n=%0d got=%b exp=%b", n, bus.int_req, m_pending); end
         checks++; if (bus.clr_flag !== m_clr) begin errors++; $display("FAIL rand_clr n=%0d got=%b exp=%b", n, bus.clr_flag, m_clr); end
         checks++; if (bus.in_service !== m_ins) begin errors++; $display("FAIL rand_ins n=%0d got=%b exp=%b", n, bus.in_service, m_ins); end
         if (m_pending) begin
            checks++; if (bus.vector !== m_vec) begin errors++; $display("FAIL rand_vec n=%0d got=%h exp=%h", n, bus.vector, m_vec); end
         end
      end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_tf0();
      test_high_beats_order();
      test_nesting();
      test_level_vs_edge();
      test_withdraw_inhibit();
      test_reset_mid_req();
      test_ack_reti_same();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
